// File: rtl/ahb_burst_master_if.sv
// Bundle of command, write/read stream, completion and AHB signals for ahb_burst_master.
// The master modport is the burst engine's view; slave is the view of whatever drives it.
interface ahb_burst_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wdata, wdata_valid,
        input  hrdata, hready, hresp,
        output cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
        output haddr, htrans, hwrite, hsize, hburst, hwdata
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wdata, wdata_valid,
        output hrdata, hready, hresp,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
        input  haddr, htrans, hwrite, hsize, hburst, hwdata
    );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCR burst with pipelined
// address/data phases, write-data stalls (BUSY), 1KB re-NONSEQ and ERROR abort.
module ahb_burst_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic               hclk,
    input  logic               hresetn,
    ahb_burst_master_if.master bus
);
    localparam int                BYTES = DATA_W / 8;
    localparam logic [2:0]        SIZE  = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BYTES);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ADDR      = 2'd1;
    localparam logic [1:0] S_DATA_LAST = 2'd2;
    localparam logic [1:0] S_ERR       = 2'd3;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] haddr_reg;
    logic              hwrite_reg;
    logic [2:0]        hsize_reg;
    logic [2:0]        hburst_reg;
    logic [DATA_W-1:0] hwdata_reg;
    logic [LEN_W-1:0]  beats_left_reg;
    logic              nonseq_reg;
    logic              dphase_reg;
    logic              cmd_ready_reg;
    logic              done_reg;
    logic              err_reg;

    logic              cmd_accept;
    logic              data_present;
    logic              addr_accept;
    logic              err_detect;
    logic              finish;
    logic              last_beat;
    logic [ADDR_W-1:0] haddr_inc;
    logic [1:0]        htrans_comb;
    logic              rdata_valid_comb;
    logic [DATA_W-1:0] rdata_comb;

    assign cmd_accept   = (state_reg == S_IDLE) && cmd_ready_reg && bus.cmd_valid;
    assign data_present = !hwrite_reg || bus.wdata_valid;
    // First ERROR cycle (hready low) beats any address hand-over in the same cycle.
    assign err_detect   = dphase_reg && bus.hresp && !bus.hready;
    assign addr_accept  = (state_reg == S_ADDR) && bus.hready && data_present && !err_detect;
    assign finish       = ((state_reg == S_DATA_LAST) || (state_reg == S_ERR)) && bus.hready;
    assign last_beat    = (beats_left_reg == '0);
    assign haddr_inc    = haddr_reg + STEP;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cmd_accept) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (err_detect)                    state_next = S_ERR;
                else if (addr_accept && last_beat) state_next = S_DATA_LAST;
            end
            S_DATA_LAST: begin
                if (err_detect)       state_next = S_ERR;
                else if (bus.hready)  state_next = S_IDLE;
            end
            S_ERR: begin
                if (bus.hready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A write beat with no data yet holds the address: BUSY mid-burst, IDLE before a NONSEQ.
    always_comb begin
        htrans_comb = HT_IDLE;
        if (state_reg == S_ADDR) begin
            if (!data_present) htrans_comb = nonseq_reg ? HT_IDLE : HT_BUSY;
            else               htrans_comb = nonseq_reg ? HT_NONSEQ : HT_SEQ;
        end
    end

    assign rdata_valid_comb = dphase_reg && !hwrite_reg && bus.hready && !bus.hresp;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_rlane
        assign rdata_comb[8*gi +: 8] = rdata_valid_comb ? bus.hrdata[8*gi +: 8] : 8'h00;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg      <= S_IDLE;
            haddr_reg      <= '0;
            hwrite_reg     <= 1'b0;
            hsize_reg      <= 3'b000;
            hburst_reg     <= 3'b000;
            hwdata_reg     <= '0;
            beats_left_reg <= '0;
            nonseq_reg     <= 1'b0;
            dphase_reg     <= 1'b0;
            cmd_ready_reg  <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            // cmd_ready stays low in the done cycle so the two never coincide.
            cmd_ready_reg <= (state_next == S_IDLE) && !finish;
            done_reg      <= finish;
            err_reg       <= finish && (state_reg == S_ERR);

            if (bus.hready) dphase_reg <= addr_accept;

            if (cmd_accept) begin
                haddr_reg      <= bus.cmd_addr;
                hwrite_reg     <= bus.cmd_wr;
                hsize_reg      <= SIZE;
                hburst_reg     <= (bus.cmd_len == '0) ? HB_SINGLE : HB_INCR;
                beats_left_reg <= bus.cmd_len;
                nonseq_reg     <= 1'b1;
            end else if (addr_accept && !last_beat) begin
                haddr_reg      <= haddr_inc;
                beats_left_reg <= beats_left_reg - LEN_W'(1);
                nonseq_reg     <= (haddr_inc[9:0] == 10'd0);
            end

            if (addr_accept && hwrite_reg) hwdata_reg <= bus.wdata;
        end
    end

    assign bus.cmd_ready   = cmd_ready_reg;
    assign bus.wdata_ready = (state_reg == S_ADDR) && hwrite_reg && bus.hready;
    assign bus.rdata       = rdata_comb;
    assign bus.rdata_valid = rdata_valid_comb;
    assign bus.done        = done_reg;
    assign bus.err         = err_reg;
    assign bus.haddr       = haddr_reg;
    assign bus.htrans      = htrans_comb;
    assign bus.hwrite      = hwrite_reg;
    assign bus.hsize       = hsize_reg;
    assign bus.hburst      = hburst_reg;
    assign bus.hwdata      = hwdata_reg;
endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: per-scenario tasks drive the command/AHB side
// cycle by cycle and compare outputs against hand-computed expectations.
module tb_ahb_burst_master;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic hclk;
    logic hresetn;
    int   checks;
    int   errors;

    ahb_burst_master_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(4)) bus ();

    ahb_burst_master #(.DATA_W(32), .ADDR_W(32), .LEN_W(4)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                             output bit ok);
        ok = 1'b0;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge hclk);
            if (bus.cmd_ready === 1'b1) ok = 1'b1;
            @(posedge hclk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        #12;
        checks++;
        if (bus.htrans !== T_IDLE || bus.haddr !== 32'h0 || bus.hwrite !== 1'b0 ||
            bus.hsize !== 3'd0 || bus.hburst !== 3'd0 || bus.hwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_ahb: htrans=%0d haddr=%h hwrite=%b hsize=%0d hburst=%0d hwdata=%h, need all zero",
                     bus.htrans, bus.haddr, bus.hwrite, bus.hsize, bus.hburst, bus.hwdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.wdata_ready !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_stream: cmd_ready=%b done=%b err=%b wdata_ready=%b rdata_valid=%b rdata=%h, need all zero",
                     bus.cmd_ready, bus.done, bus.err, bus.wdata_ready, bus.rdata_valid, bus.rdata);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready: got %b need 1", bus.cmd_ready);
        end
        $display("txn reset: done");
    endtask

    task automatic test_single_write();
        bit ok;
        issue_cmd(1'b1, 32'h4000_0004, 4'd0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_write_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 4; cyc++) begin
            bus.wdata       = 32'h2;
            bus.wdata_valid = (cyc == 1);
            bus.hready      = 1'b1;
            @(negedge hclk);
            if (cyc == 1) begin
                checks++;
                if (bus.htrans !== T_NONSEQ || bus.haddr !== 32'h4000_0004 || bus.hburst !== 3'd0 ||
                    bus.hsize !== 3'd2 || bus.hwrite !== 1'b1 || bus.wdata_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_write_addr: htrans=%0d haddr=%h hburst=%0d hsize=%0d hwrite=%b wready=%b need 2/40000004/0/2/1/1",
                             bus.htrans, bus.haddr, bus.hburst, bus.hsize, bus.hwrite, bus.wdata_ready);
                end
            end else if (cyc == 2) begin
                checks++;
                if (bus.htrans !== T_IDLE || bus.hwdata !== 32'h2 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL single_write_data: htrans=%0d hwdata=%h done=%b need 0/00000002/0",
                             bus.htrans, bus.hwdata, bus.done);
                end
            end else if (cyc == 3) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL single_write_done: done=%b err=%b cmd_ready=%b need 1/0/0",
                             bus.done, bus.err, bus.cmd_ready);
                end
            end else begin
                checks++;
                if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_write_after: done=%b cmd_ready=%b need 0/1", bus.done, bus.cmd_ready);
                end
            end
            @(posedge hclk); #1;
        end
        bus.wdata_valid = 1'b0;
        $display("txn single_write addr=40000004 len=0");
    endtask

    task automatic test_incr4_read();
        bit ok;
        int pulses;
        logic [31:0] exp_addr [1:4];
        logic [1:0]  exp_tr   [1:4];
        exp_addr = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
        exp_tr   = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ};
        pulses = 0;
        issue_cmd(1'b0, 32'h8000_0000, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL incr4_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            bus.hready = 1'b1;
            bus.hrdata = (cyc >= 2 && cyc <= 5) ? 32'hA + 32'(cyc - 2) : 32'hDEAD_BEEF;
            @(negedge hclk);
            if (bus.rdata_valid === 1'b1) pulses++;
            if (cyc <= 4) begin
                checks++;
                if (bus.htrans !== exp_tr[cyc] || bus.haddr !== exp_addr[cyc] || bus.hburst !== 3'd1) begin
                    errors++;
                    $display("FAIL incr4_addr%0d: htrans=%0d haddr=%h hburst=%0d need %0d/%h/1",
                             cyc, bus.htrans, bus.haddr, bus.hburst, exp_tr[cyc], exp_addr[cyc]);
                end
            end
            if (cyc >= 2 && cyc <= 5) begin
                checks++;
                if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hA + 32'(cyc - 2)) begin
                    errors++;
                    $display("FAIL incr4_rdata%0d: valid=%b rdata=%h need 1/%h",
                             cyc, bus.rdata_valid, bus.rdata, 32'hA + 32'(cyc - 2));
                end
            end
            if (cyc == 5) begin
                checks++;
                if (bus.htrans !== T_IDLE) begin
                    errors++;
                    $display("FAIL incr4_last_idle: htrans=%0d need 0", bus.htrans);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.rdata_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL incr4_done: done=%b err=%b rvalid=%b need 1/0/0",
                             bus.done, bus.err, bus.rdata_valid);
                end
            end
            @(posedge hclk); #1;
        end
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL incr4_pulses: got %0d need 4", pulses); end
        $display("txn incr4_read addr=80000000 len=3 beats=%0d", pulses);
    endtask

    task automatic test_wait_states();
        bit ok;
        int xfers;
        logic [31:0] data [0:3];
        logic [31:0] exp_addr [1:6];
        logic [1:0]  exp_tr   [1:7];
        logic [31:0] exp_wd   [2:7];
        data     = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h1008, 32'h1008, 32'h100C};
        exp_tr   = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
        exp_wd   = '{32'h11, 32'h22, 32'h22, 32'h22, 32'h33, 32'h44};
        xfers = 0;
        issue_cmd(1'b1, 32'h1000, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            bus.hready      = !(cyc == 3 || cyc == 4);
            bus.wdata_valid = (xfers < 4);
            bus.wdata       = data[xfers < 4 ? xfers : 3];
            @(negedge hclk);
            if (bus.wdata_valid === 1'b1 && bus.wdata_ready === 1'b1) xfers++;
            if (cyc <= 7) begin
                checks++;
                if (bus.htrans !== exp_tr[cyc] || (cyc <= 6 && bus.haddr !== exp_addr[cyc])) begin
                    errors++;
                    $display("FAIL wait_addr%0d: htrans=%0d haddr=%h need %0d/%h",
                             cyc, bus.htrans, bus.haddr, exp_tr[cyc], exp_addr[cyc < 7 ? cyc : 6]);
                end
            end
            if (cyc >= 2 && cyc <= 7) begin
                checks++;
                if (bus.hwdata !== exp_wd[cyc]) begin
                    errors++;
                    $display("FAIL wait_hwdata%0d: got %h need %h", cyc, bus.hwdata, exp_wd[cyc]);
                end
            end
            if (cyc == 8) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_done: done=%b err=%b need 1/0", bus.done, bus.err);
                end
            end
            @(posedge hclk); #1;
        end
        bus.hready      = 1'b1;
        bus.wdata_valid = 1'b0;
        checks++;
        if (xfers != 4) begin errors++; $display("FAIL wait_xfers: got %0d need 4", xfers); end
        $display("txn wait_states addr=00001000 len=3 wdata_xfers=%0d", xfers);
    endtask

    task automatic test_write_stall();
        bit ok;
        int xfers;
        logic [31:0] data [0:3];
        logic [31:0] exp_addr [1:8];
        logic [1:0]  exp_tr   [1:9];
        data     = '{32'h51, 32'h52, 32'h53, 32'h54};
        exp_addr = '{32'h2000, 32'h2000, 32'h2004, 32'h2008, 32'h2008, 32'h2008, 32'h2008, 32'h200C};
        exp_tr   = '{T_IDLE, T_NONSEQ, T_SEQ, T_BUSY, T_BUSY, T_BUSY, T_SEQ, T_SEQ, T_IDLE};
        xfers = 0;
        issue_cmd(1'b1, 32'h2000, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            bus.hready      = 1'b1;
            bus.wdata_valid = (xfers < 4) && !(cyc == 1 || (cyc >= 4 && cyc <= 6));
            bus.wdata       = data[xfers < 4 ? xfers : 3];
            @(negedge hclk);
            if (bus.wdata_valid === 1'b1 && bus.wdata_ready === 1'b1) xfers++;
            if (cyc <= 9) begin
                checks++;
                if (bus.htrans !== exp_tr[cyc] || (cyc <= 8 && bus.haddr !== exp_addr[cyc])) begin
                    errors++;
                    $display("FAIL stall_addr%0d: htrans=%0d haddr=%h need %0d/%h",
                             cyc, bus.htrans, bus.haddr, exp_tr[cyc], exp_addr[cyc < 9 ? cyc : 8]);
                end
            end
            if (cyc >= 4 && cyc <= 6) begin
                checks++;
                if (bus.wdata_ready !== 1'b1 || bus.hwdata !== 32'h52) begin
                    errors++;
                    $display("FAIL stall_busy%0d: wready=%b hwdata=%h need 1/00000052",
                             cyc, bus.wdata_ready, bus.hwdata);
                end
            end
            if (cyc == 9) begin
                checks++;
                if (bus.hwdata !== 32'h54) begin
                    errors++;
                    $display("FAIL stall_last_hwdata: got %h need 00000054", bus.hwdata);
                end
            end
            if (cyc == 10) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_done: done=%b err=%b need 1/0", bus.done, bus.err);
                end
            end
            @(posedge hclk); #1;
        end
        bus.wdata_valid = 1'b0;
        checks++;
        if (xfers != 4) begin errors++; $display("FAIL stall_xfers: got %0d need 4", xfers); end
        $display("txn write_stall addr=00002000 len=3 wdata_xfers=%0d", xfers);
    endtask

    task automatic test_error();
        bit ok;
        int pulses;
        pulses = 0;
        issue_cmd(1'b0, 32'h3000, 4'd7, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL error_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            bus.hready = (cyc != 4);
            bus.hresp  = (cyc == 4 || cyc == 5);
            bus.hrdata = 32'hE0 + 32'(cyc);
            @(negedge hclk);
            if (bus.rdata_valid === 1'b1) pulses++;
            if (cyc == 4) begin
                checks++;
                if (bus.htrans !== T_SEQ || bus.haddr !== 32'h300C || bus.rdata_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL error_first: htrans=%0d haddr=%h rvalid=%b need 3/0000300c/0",
                             bus.htrans, bus.haddr, bus.rdata_valid);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (bus.htrans !== T_IDLE || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL error_idle: htrans=%0d done=%b need 0/0", bus.htrans, bus.done);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.htrans !== T_IDLE) begin
                    errors++;
                    $display("FAIL error_done: done=%b err=%b htrans=%0d need 1/1/0",
                             bus.done, bus.err, bus.htrans);
                end
            end
            if (cyc == 7) begin
                checks++;
                if (bus.err !== 1'b0 || bus.htrans !== T_IDLE) begin
                    errors++;
                    $display("FAIL error_after: err=%b htrans=%0d need 0/0", bus.err, bus.htrans);
                end
            end
            @(posedge hclk); #1;
        end
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL error_pulses: got %0d need 2", pulses); end
        $display("txn error_read addr=00003000 len=7 rdata_pulses=%0d", pulses);
    endtask

    task automatic test_boundary();
        bit ok;
        logic [31:0] exp_addr [1:4];
        logic [1:0]  exp_tr   [1:5];
        exp_addr = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        exp_tr   = '{T_NONSEQ, T_SEQ, T_NONSEQ, T_SEQ, T_IDLE};
        issue_cmd(1'b0, 32'h0000_03F8, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL boundary_accept: cmd_ready timeout got 0 need 1"); end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            bus.hready = 1'b1;
            bus.hrdata = 32'h77;
            @(negedge hclk);
            if (cyc <= 5) begin
                checks++;
                if (bus.htrans !== exp_tr[cyc] || (cyc <= 4 && (bus.haddr !== exp_addr[cyc] || bus.hburst !== 3'd1))) begin
                    errors++;
                    $display("FAIL boundary_addr%0d: htrans=%0d haddr=%h hburst=%0d need %0d/%h/1",
                             cyc, bus.htrans, bus.haddr, bus.hburst, exp_tr[cyc], exp_addr[cyc < 5 ? cyc : 4]);
                end
            end else begin
                checks++;
                if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL boundary_done: done=%b err=%b need 1/0", bus.done, bus.err);
                end
            end
            @(posedge hclk); #1;
        end
        $display("txn boundary_read addr=000003f8 len=3");
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int done_seen;
        done_seen = 0;
        issue_cmd(1'b0, 32'h5000, 4'd3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_accept: cmd_ready timeout got 0 need 1"); end
        bus.hready = 1'b1;
        bus.hrdata = 32'h99;
        @(posedge hclk); #1;
        bus.hrdata = 32'h9A;
        #2;
        checks++;
        if (bus.htrans !== T_SEQ || bus.haddr !== 32'h5004) begin
            errors++;
            $display("FAIL midrst_beat2: htrans=%0d haddr=%h need 3/00005004", bus.htrans, bus.haddr);
        end
        hresetn = 1'b0;
        #1;
        checks++;
        if (bus.htrans !== T_IDLE || bus.haddr !== 32'h0 || bus.hburst !== 3'd0 || bus.hsize !== 3'd0 ||
            bus.hwrite !== 1'b0 || bus.hwdata !== 32'h0 || bus.cmd_ready !== 1'b0 ||
            bus.rdata_valid !== 1'b0 || bus.rdata !== 32'h0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: htrans=%0d haddr=%h hburst=%0d hsize=%0d cmd_ready=%b rvalid=%b done=%b need all zero",
                     bus.htrans, bus.haddr, bus.hburst, bus.hsize, bus.cmd_ready, bus.rdata_valid, bus.done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            if (bus.done !== 1'b0 || bus.err !== 1'b0) done_seen++;
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.htrans !== T_IDLE) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midrst_no_done: activity cycles got %0d need 0", done_seen);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: cmd_ready got %b need 1", bus.cmd_ready);
        end
        @(posedge hclk); #1;
        $display("txn reset_midburst addr=00005000 aborted");
    endtask

    task automatic test_back_to_back();
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = 32'h6000;
        bus.cmd_len   = 4'd0;
        bus.cmd_valid = 1'b1;
        bus.hready    = 1'b1;
        bus.hrdata    = 32'h66;
        for (int cyc = 0; cyc <= 7; cyc++) begin
            if (cyc == 1) bus.cmd_addr  = 32'h6100;
            if (cyc == 5) bus.cmd_valid = 1'b0;
            @(negedge hclk);
            case (cyc)
                0, 4: begin
                    checks++;
                    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_ready%0d: cmd_ready=%b done=%b need 1/0", cyc, bus.cmd_ready, bus.done);
                    end
                end
                1, 5: begin
                    checks++;
                    if (bus.htrans !== T_NONSEQ || bus.haddr !== (cyc == 1 ? 32'h6000 : 32'h6100) ||
                        bus.cmd_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_addr%0d: htrans=%0d haddr=%h cmd_ready=%b need 2/%h/0",
                                 cyc, bus.htrans, bus.haddr, bus.cmd_ready, (cyc == 1 ? 32'h6000 : 32'h6100));
                    end
                end
                2, 6: begin
                    checks++;
                    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h66 || bus.cmd_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_data%0d: rvalid=%b rdata=%h cmd_ready=%b need 1/00000066/0",
                                 cyc, bus.rdata_valid, bus.rdata, bus.cmd_ready);
                    end
                end
                default: begin
                    checks++;
                    if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_done%0d: done=%b cmd_ready=%b need 1/0", cyc, bus.done, bus.cmd_ready);
                    end
                end
            endcase
            @(posedge hclk); #1;
        end
        $display("txn back_to_back addr=00006000,00006100");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata       = '0;
        bus.wdata_valid = 1'b0;
        bus.hrdata      = '0;
        bus.hready      = 1'b1;
        bus.hresp       = 1'b0;
        test_reset();
        test_single_write();
        test_incr4_read();
        test_wait_states();
        test_write_stall();
        test_error();
        test_boundary();
        test_reset_midburst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 Parameter DATA_W, default 32, data bus width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter LEN_W, default 4, width of cmd_len; bursts are 1..2^LEN_W beats.
REQ-004 hclk  in  1  clock; all flops rise on posedge hclk.
REQ-005 hresetn  in  1  asynchronous active-low reset.
REQ-006 cmd_valid/cmd_ready  in/out  1  command handshake; a command transfers when both are high on a posedge.
REQ-007 cmd_wr  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  ADDR_W  start address, DATA_W/8-aligned.
REQ-009 cmd_len  in  LEN_W  beats minus 1.
REQ-010 wdata/wdata_valid/wdata_ready  in/in/out  DATA_W/1/1  write-data stream; a beat transfers when valid and ready are both high.
REQ-011 rdata/rdata_valid  out  DATA_W/1  read-data stream, no backpressure.
REQ-012 done/err  out  1/1  one-cycle pulses at command end; err is high with done when a burst aborts.
REQ-013 haddr, htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hwdata  out  AHB master outputs.
REQ-014 hrdata, hready, hresp  in  AHB slave responses; hresp 0 = OKAY, 1 = ERROR.

Function
REQ-015 FSM states: IDLE, ADDR, DATA_LAST, ERR.
- cmd_ready is high only in IDLE.
REQ-016 Command acceptance: IDLE -> ADDR and latch cmd fields.
- Next cycle: htrans=NONSEQ, haddr=cmd_addr, hsize=log2(DATA_W/8), hburst=SINGLE(000) if cmd_len=0, else INCR(001).
REQ-017 Pipelining: address and control advance only on posedge with hready=1.
- The data phase of beat n overlaps the address phase of beat n+1.
REQ-018 Address sequence: each later beat adds DATA_W/8 to haddr.
- htrans=SEQ, except at a 1KB boundary (new haddr[9:0]==0), where htrans=NONSEQ and hburst stays INCR.
REQ-019 After the last address phase is accepted: ADDR -> DATA_LAST, htrans=IDLE.
- DATA_LAST -> IDLE on hready=1, pulsing done in that cycle.
REQ-020 Write beats: wdata_ready is high in ADDR when hwrite=1 and hready=1.
- The transferred wdata is registered to hwdata for the following data phase.
- hwdata holds until hready=1 in the data phase.
REQ-021 Write stall: wdata_valid low with wdata_ready high holds haddr.
- Drives htrans=BUSY on a non-first beat, or IDLE (stays in ADDR) on the first beat.
- The address phase is not accepted by the master until data is present.
REQ-022 Reads: rdata=hrdata and rdata_valid=1 for exactly the cycles where a read data phase completes (hready=1, hresp=0).
REQ-023 Error: hresp=1 with hready=0 in any data phase moves to ERR and drives htrans=IDLE in the next cycle.
- Remaining beats are cancelled, and no further wdata is accepted.
- ERR -> IDLE on hready=1, pulsing done and err together.
REQ-024 Simultaneous events: an error response in the same cycle a new address would be accepted means the address is treated as cancelled (IDLE issued); error handling takes priority.
REQ-025 done and cmd_ready are never high in the same cycle; the next command is accepted at the earliest one cycle after done.
REQ-026 Read data phases never produce rdata_valid while hready=0.

Reset
REQ-027 Reset sets state=IDLE, htrans=IDLE(00), haddr=0, hwrite=0, hsize=0, hburst=0, hwdata=0.
- It also sets cmd_ready=0 during reset and 1 in the first cycle after release, and rdata=0, rdata_valid=0, wdata_ready=0, done=0, err=0.
REQ-028 Reset asserted mid-burst aborts immediately with no done/err pulse; the burst is not resumed.

Verification
REQ-029 Single write: addr 0x4000_0004, len 0, wdata 0x2, hready=1 -> NONSEQ, SINGLE, hwrite=1, hwdata=0x2 next cycle, done 2 cycles after the address phase.
REQ-030 INCR4 read: addr 0x8000_0000, slave returns 0xA..0xD with no waits -> haddr 0x..00,04,08,0C; htrans NONSEQ,SEQ,SEQ,SEQ; four consecutive rdata_valid; done with no err.
REQ-031 Wait states: INCR4 write with hready low 2 cycles on beat 2 -> haddr/htrans and hwdata held stable through the wait; exactly 4 wdata transfers.
REQ-032 Write stall: wdata_valid low 3 cycles before beat 3 -> htrans=BUSY for 3 cycles with haddr held, then SEQ.
REQ-033 Error: INCR8 read, ERROR on beat 3 -> htrans=IDLE the cycle after the first ERROR cycle; 2 rdata_valid pulses; done+err together.
REQ-034 Boundary/reset: INCR4 at 0x0000_03F8 -> beat 3 at 0x400 uses NONSEQ; separately, hresetn low during beat 2 -> all outputs at reset values asynchronously, no done pulse.
